// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla_nibble_slice.sv
// 4-bit carry-look-ahead adder slice; purely combinational, no backpressure.
module cla_nibble_slice
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from g/p and cin, so no carry ripples inside the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one nibble per cycle, result handshake NIBBLES+1 edges after accept, held until out_ready.
// Optional signed-overflow output ovf when NSA_OVERFLOW_FLAG_EN is defined.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
`ifdef NSA_OVERFLOW_FLAG_EN
  ,
  output logic                        ovf
`endif
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int MSB   = W - 1;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last;

  assign last = (idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla_nibble_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef NSA_OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          end
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            cout <= slice_cout;
`ifdef NSA_OVERFLOW_FLAG_EN
            // The last slice produces the sum MSB, so overflow resolves in the same cycle as cout.
            ovf  <= (a_q[MSB] == b_q[MSB]) && (slice_sum[NIBBLE_W-1] != a_q[MSB]);
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width is 4*NIBBLES bits, legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand request.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, 4*NIBBLES bits: operand A.
REQ-007 SHALL have port b, input, 4*NIBBLES bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port sum, output, 4*NIBBLES bits: registered sum.
REQ-012 SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1, latch a, b and cin into operand registers, clear the nibble index, and go to RUN.
REQ-016 SHALL, in each RUN cycle, add nibble[idx] of A and B plus the carry register through one 4-bit carry-look-ahead slice, write the slice sum into sum[4*idx+3:4*idx], load the slice carry into the carry register, and increment idx.
REQ-017 SHALL use cin as the carry into nibble 0.
REQ-018 SHALL leave RUN for DONE after processing nibble NIBBLES-1, with cout equal to the final slice carry.
REQ-019 SHALL assert out_valid exactly NIBBLES+1 rising edges after the accepting edge.
REQ-020 SHALL hold sum and cout stable in DONE until out_ready=1 is sampled, then go to IDLE.
REQ-021 SHALL NOT accept new operands in the same cycle as a DONE->IDLE transition; minimum spacing between accepts is NIBBLES+2 cycles.
REQ-022 SHALL ignore in_valid outside IDLE; changes to a, b or cin after acceptance SHALL NOT affect the result.
REQ-023 SHALL compute sum and cout as (a+b+cin) modulo 2^(4*NIBBLES+1), full-width unsigned, with no saturation.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-RUN, go immediately to IDLE, abort the operation and discard it.
REQ-025 SHALL have reset values sum=0, cout=0, out_valid=0, in_ready=1 (once rst_n deasserts); the index, carry and operand registers SHALL reset to 0.

Configuration
REQ-026 SHALL use macro NSA_OVERFLOW_FLAG_EN to compile a signed-overflow output in or out.
REQ-027 SHALL, with NSA_OVERFLOW_FLAG_EN defined, add output port ovf, 1 bit, registered with cout; ovf=1 iff a[msb]==b[msb] and sum[msb]!=a[msb]; reset value 0.
REQ-028 SHALL, without NSA_OVERFLOW_FLAG_EN, have no ovf port and no related logic.

Structure
REQ-029 SHALL place the FSM state enum and the NIBBLE_W=4 constant in shared package adder_pkg.
REQ-030 SHALL instantiate exactly one combinational sub-module, cla_nibble_slice (4-bit generate/propagate look-ahead: inputs a, b, cin; outputs sum, cout).

Verification
REQ-031 SHALL test a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid high 5 edges after accept.
REQ-032 SHALL test a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; with the macro: a=0x7FFF, b=0x0001 -> ovf=1.
REQ-033 SHALL test backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/cout stable, in_ready=0 throughout, result taken on first out_ready=1.
REQ-034 SHALL test reset mid-op: assert rst_n=0 during the RUN cycle of nibble 2 -> out_valid=0, sum=0, next operation correct.
REQ-035 SHALL test in_valid held high continuously -> one accept per NIBBLES+2 cycles, and operand changes during RUN are ignored.
REQ-036 SHALL run a 10k-transaction random test against a+b+cin with random valid/ready stalls.
